gpr_scoreboard_rf: RTL

- Next-generation general register file for the pipelined CPU's decode stage.
- Generalises the fixed 2-read/1-write 32x32 register file to parametrised width, depth and read-port count.
- Adds an internal write-to-read bypass and a per-register pending-write scoreboard, so decode can detect RAW hazards and stall without external comparators.
- Sits in ID; written from WB; busy state set at issue, cleared at writeback or on exception flush.

---
 rtl/gpr_scoreboard_rf.sv | 97 +++++++++
 1 files changed

// File: rtl/gpr_scoreboard_rf.sv
// Register file with write-to-read bypass and per-register pending-write counters.
// Define RF_TRACE_EN to print a trace line for every committed write.
module gpr_scoreboard_rf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*DATA_W-1:0]    rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_wa,
    output logic                     iss_ready,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [31:0]              pc,
    input  logic                     flush,
    output logic                     stall
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [CNT_W-1:0]  cnt_q  [NREG];
    logic [CNT_W-1:0]  cnt_d  [NREG];
    logic [NREG-1:0]   dec;
    logic [NREG-1:0]   inc;
    logic              wr_hit;

    assign wr_hit = we && (wa != '0);

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            dec[r] = wr_hit && (wa == ADDR_W'(r)) && (cnt_q[r] != '0);
        end
    end

    // A retiring write frees a slot in the same cycle, so a full counter can still accept
    assign iss_ready = (iss_wa == '0) || (cnt_q[iss_wa] != '1) || dec[iss_wa];

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            inc[r] = iss_valid && iss_ready
                  && (iss_wa == ADDR_W'(r)) && (r != 0);
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else if (inc[r] && !dec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec[r] && !inc[r]) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            if (wr_hit) begin
                regs_q[wa] <= wd;
            end
            cnt_q <= cnt_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[i*ADDR_W +: ADDR_W];
        assign rd_data[i*DATA_W +: DATA_W] =
            (wr_hit && (wa == ra)) ? wd : regs_q[ra];
        // The last outstanding write retiring now is covered by the bypass
        assign rd_busy[i] = (ra != '0) && (cnt_q[ra] != '0)
                         && !((cnt_q[ra] == CNT_W'(1)) && dec[ra]);
    end

    assign stall = |rd_busy;

`ifdef RF_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && wr_hit) begin
            $display("@%h: $%d <= %h", pc, wa, wd);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule
